// File: rtl/mem_access_unit_if.sv
// Pipeline MEM-stage request/response bus plus the data-memory port of the load/store unit.
// The slave modport is the unit; the master modport is the pipeline/memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic [ADDR_W-1:0] dm_a;
  logic [ADDR_W-1:0] dm_dpra;
  logic              dm_we;
  logic [31:0]       dm_d;
  logic [31:0]       dm_dpo;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_dpo,
    output req_ready, resp_valid, resp_rdata, resp_fault, dm_a, dm_dpra, dm_we, dm_d
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_dpo,
    input  req_ready, resp_valid, resp_rdata, resp_fault, dm_a, dm_dpra, dm_we, dm_d
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer over a word memory; loads/SW respond at T+2, SB/SH (RMW) at T+3, faults at T+1.
// One request in flight, req_ready only in IDLE; define MAU_RANGE_CHECK_EN to fault on addresses beyond the memory.
module mem_access_unit #(
  parameter int ADDR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rmw_q, rmw_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic              acc_fault;
  logic              range_bad;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;
  logic [31:0]       wr_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      rmw_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      rmw_q   <= rmw_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

`ifdef MAU_RANGE_CHECK_EN
  assign range_bad = |bus.req_addr[31:ADDR_W+2];
`else
  assign range_bad = 1'b0;
`endif

  always_comb begin
    acc_fault = range_bad;
    case (bus.req_size)
      2'b01:   acc_fault = acc_fault | bus.req_addr[0];
      2'b10:   acc_fault = acc_fault | (bus.req_addr[1:0] != 2'b00);
      2'b11:   acc_fault = 1'b1;
      default: acc_fault = acc_fault;
    endcase
  end

  // Load lane extraction and extension work off the live async read data.
  always_comb begin
    ld_byte = bus.dm_dpo[8*lane_q +: 8];
    ld_half = lane_q[1] ? bus.dm_dpo[31:16] : bus.dm_dpo[15:0];
    case (size_q)
      2'b00:   ld_val = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_val = bus.dm_dpo;
    endcase
  end

  always_comb begin
    wr_word = rmw_q;
    case (size_q)
      2'b00:   wr_word[8*lane_q +: 8] = wdata_q[7:0];
      2'b01: begin
        if (lane_q[1]) wr_word[31:16] = wdata_q[15:0];
        else           wr_word[15:0]  = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    rmw_d   = rmw_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          word_d  = bus.req_addr[ADDR_W+1:2];
          lane_d  = bus.req_addr[1:0];
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          wdata_d = bus.req_wdata;
          if (acc_fault) begin
            fault_d = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else if (!bus.req_we) begin
            state_d = LOAD;
          end else if (bus.req_size == 2'b10) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        rdata_d = ld_val;
        fault_d = 1'b0;
        state_d = RESP;
      end
      RMW_RD: begin
        rmw_d   = bus.dm_dpo;
        state_d = WRITE;
      end
      WRITE: begin
        rdata_d = '0;
        fault_d = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes decode from the state register only, so reset kills dm_we immediately.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
  assign bus.dm_we      = (state_q == WRITE);
  assign bus.dm_a       = (state_q == IDLE) ? '0 : word_q;
  assign bus.dm_dpra    = (state_q == IDLE) ? '0 : word_q;
  assign bus.dm_d       = (state_q == WRITE) ? wr_word : '0;

endmodule
